// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg
//   Shared definitions for the counter sequencer slice.
//   - CNT_W   : default counter / value width
//   - state_t : sequencer state encoding (also used on the debug port)
package counter_seq_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_COUNT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/seq_counter.sv
// seq_counter
//   N-bit loadable up-counter, wraps modulo 2^N.
//   Priority: reset, then load, then count enable.
//   Ports:
//     clk      - rising-edge clock
//     reset_n  - synchronous active-low reset (clears count to 0)
//     load_en  - load data_in on the next edge
//     data_in  - load value
//     cnt_en   - increment by one on the next edge
//     count    - current counter value
module seq_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_en,
  input  logic [N-1:0] data_in,
  input  logic         cnt_en,
  output logic [N-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load_en) begin
      count <= data_in;
    end else if (cnt_en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Sequences a loadable up-counter from a captured start value to a captured
//   end value, pulses done, and optionally repeats the interval.
//   Ports:
//     clk, reset_n  - clock and synchronous active-low reset
//     start         - request a new interval (accepted only while idle)
//     start_val     - counter load value, captured on acceptance
//     end_val       - terminal count, captured on acceptance
//     auto_reload   - repeat the interval forever, captured on acceptance
//     abort         - return to idle from any busy state, no done
//     busy          - high whenever the sequencer is not idle
//     done          - one-cycle pulse while in the DONE state
//     count_out     - current counter value
//     state_dbg     - current FSM state, for observation only
//
//   Request handshake: start acts as valid and !busy as ready. A request is
//   accepted on the rising edge where start=1 and busy=0 (abort is ignored
//   while idle, so it never blocks acceptance). The requester need not hold
//   start or the value inputs after that edge; start while busy is dropped.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int N = CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] start_val,
  input  logic [N-1:0] end_val,
  input  logic         auto_reload,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] count_out,
  output state_t       state_dbg
);

  state_t       state_q;
  state_t       state_d;
  logic [N-1:0] s_reg;
  logic [N-1:0] e_reg;
  logic         ar_reg;
  logic         load_en;
  logic         cnt_en;
  logic         at_end;

  assign at_end = (count_out == e_reg);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and counter controls. Abort gates both controls so the
  // count freezes at the value it had when abort was sampled.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    cnt_en  = 1'b0;
    if ((state_q != ST_IDLE) && abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_LOAD;
        ST_LOAD: begin
          load_en = 1'b1;
          state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (at_end) state_d = ST_DONE;
          else        cnt_en  = 1'b1;
        end
        ST_DONE:  state_d = ar_reg ? ST_LOAD : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Capture registers: written only when a request is accepted, so reloads
  // reuse the original interval and abort leaves them untouched.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_reg  <= '0;
      e_reg  <= '0;
      ar_reg <= 1'b0;
    end else if ((state_q == ST_IDLE) && start) begin
      s_reg  <= start_val;
      e_reg  <= end_val;
      ar_reg <= auto_reload;
    end
  end

  seq_counter #(.N(N)) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load_en (load_en),
    .data_in (s_reg),
    .cnt_en  (cnt_en),
    .count   (count_out)
  );

  // Outputs decoded straight from the state register
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [N-1:0] start_val;
  logic [N-1:0] end_val;
  logic         auto_reload;
  logic         abort;
  logic         busy;
  logic         done;
  logic [N-1:0] count_out;
  state_t       state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.N(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .start_val   (start_val),
    .end_val     (end_val),
    .auto_reload (auto_reload),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .count_out   (count_out),
    .state_dbg   (state_dbg)
  );

  // Watchdog: the bench is fixed-length, this only guards against a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required earlier finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Advance one active edge; everything is sampled and driven 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the value inputs to show
  // they are not needed after acceptance. Returns after edge k.
  task automatic issue_start(input logic [N-1:0] s, input logic [N-1:0] e,
                             input logic ar);
    start       = 1'b1;
    start_val   = s;
    end_val     = e;
    auto_reload = ar;
    tick();
    start       = 1'b0;
    start_val   = 8'hA5;
    end_val     = 8'h5A;
    auto_reload = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n     = 1'b0;
    start       = 1'b1;
    start_val   = 8'h77;
    end_val     = 8'h78;
    auto_reload = 1'b1;
    abort       = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    start   = 1'b0;
    n_checks++;
    if (count_out !== 8'h00) $display("FAIL reset_count: got %h required %h", count_out, 8'h00);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done);
    else n_pass++;
    n_checks++;
    if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d required %0d", state_dbg, ST_IDLE);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_start_ignored: busy got %b required 0", busy);
    else n_pass++;
  endtask

  // S=03 E=05, D=2: count 03,04,05 after k+1..k+3, done after k+4, idle after k+5
  task automatic test_basic();
    logic [N-1:0] exp_cnt [3];
    exp_cnt[0] = 8'h03; exp_cnt[1] = 8'h04; exp_cnt[2] = 8'h05;
    issue_start(8'h03, 8'h05, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || state_dbg !== ST_LOAD)
      $display("FAIL basic_load: busy=%b state=%0d required busy=1 state=%0d", busy, state_dbg, ST_LOAD);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (count_out !== exp_cnt[i] || done !== 1'b0)
        $display("FAIL basic_count[%0d]: got count=%h done=%b required count=%h done=0",
                 i, count_out, done, exp_cnt[i]);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || count_out !== 8'h05 || busy !== 1'b1)
      $display("FAIL basic_done: got done=%b count=%h busy=%b required 1/05/1", done, count_out, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || count_out !== 8'h05)
      $display("FAIL basic_idle: got done=%b busy=%b count=%h required 0/0/05", done, busy, count_out);
    else n_pass++;
  endtask

  // S=FE E=01, D=3: FE,FF,00,01 after k+1..k+4, done only after k+5
  task automatic test_wrap();
    logic [N-1:0] exp_cnt [4];
    exp_cnt[0] = 8'hFE; exp_cnt[1] = 8'hFF; exp_cnt[2] = 8'h00; exp_cnt[3] = 8'h01;
    issue_start(8'hFE, 8'h01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (count_out !== exp_cnt[i] || done !== 1'b0)
        $display("FAIL wrap_count[%0d]: got count=%h done=%b required count=%h done=0",
                 i, count_out, done, exp_cnt[i]);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || count_out !== 8'h01)
      $display("FAIL wrap_done: got done=%b count=%h required 1/01", done, count_out);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL wrap_idle: busy got %b required 0", busy);
    else n_pass++;
  endtask

  // S=E=38: count 38 after k+1, done after k+2, idle after k+3
  task automatic test_equal();
    issue_start(8'h38, 8'h38, 1'b0);
    tick();
    n_checks++;
    if (count_out !== 8'h38 || done !== 1'b0)
      $display("FAIL equal_load: got count=%h done=%b required 38/0", count_out, done);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b1 || count_out !== 8'h38)
      $display("FAIL equal_done: got done=%b count=%h required 1/38", done, count_out);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count_out !== 8'h38)
      $display("FAIL equal_idle: got busy=%b done=%b count=%h required 0/0/38", busy, done, count_out);
    else n_pass++;
  endtask

  // S=10 E=12 with reload: period 5, done after base+4; stray start ignored; abort ends it
  task automatic test_reload();
    logic [N-1:0] exp_cnt [3];
    exp_cnt[0] = 8'h10; exp_cnt[1] = 8'h11; exp_cnt[2] = 8'h12;
    issue_start(8'h10, 8'h12, 1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        if (p == 1 && i == 1) begin
          start       = 1'b0;
          start_val   = 8'h10;
          end_val     = 8'h12;
        end
        n_checks++;
        if (count_out !== exp_cnt[i] || done !== 1'b0 || busy !== 1'b1)
          $display("FAIL reload_count[p%0d,%0d]: got count=%h done=%b busy=%b required %h/0/1",
                   p, i, count_out, done, busy, exp_cnt[i]);
        else n_pass++;
        if (p == 1 && i == 0) begin
          start     = 1'b1;
          start_val = 8'hFF;
          end_val   = 8'hFF;
        end
      end
      tick();
      n_checks++;
      if (done !== 1'b1 || count_out !== 8'h12)
        $display("FAIL reload_done[p%0d]: got done=%b count=%h required 1/12", p, done, count_out);
      else n_pass++;
      tick();
      n_checks++;
      if (state_dbg !== ST_LOAD || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL reload_load[p%0d]: got state=%0d busy=%b done=%b required %0d/1/0",
                 p, state_dbg, busy, done, ST_LOAD);
      else n_pass++;
    end
    tick();   // count 10
    tick();   // count 11
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || count_out !== 8'h11 || state_dbg !== ST_IDLE)
      $display("FAIL reload_abort: got busy=%b count=%h state=%0d required 0/11/%0d",
               busy, count_out, state_dbg, ST_IDLE);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || count_out !== 8'h11)
        $display("FAIL reload_after_abort[%0d]: got done=%b busy=%b count=%h required 0/0/11",
                 i, done, busy, count_out);
      else n_pass++;
    end
  endtask

  // S=00 E=09: abort while count shows 04, count freezes, busy drops next edge
  task automatic test_abort();
    issue_start(8'h00, 8'h09, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (count_out !== 8'h04) $display("FAIL abort_pre: got count=%h required 04", count_out);
    else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (count_out !== 8'h04 || busy !== 1'b0)
      $display("FAIL abort_freeze: got count=%h busy=%b required 04/0", count_out, busy);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || count_out !== 8'h04)
        $display("FAIL abort_quiet[%0d]: got done=%b count=%h required 0/04", i, done, count_out);
      else n_pass++;
    end
  endtask

  // abort together with start in IDLE: start still accepted
  task automatic test_abort_start_idle();
    abort = 1'b1;
    issue_start(8'h20, 8'h20, 1'b0);
    abort = 1'b0;
    n_checks++;
    if (state_dbg !== ST_LOAD || busy !== 1'b1)
      $display("FAIL idle_abort_start: got state=%0d busy=%b required %0d/1", state_dbg, busy, ST_LOAD);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (done !== 1'b1 || count_out !== 8'h20)
      $display("FAIL idle_abort_done: got done=%b count=%h required 1/20", done, count_out);
    else n_pass++;
    tick();
  endtask

  // S=40 E=50: reset at the edge where count would leave 42
  task automatic test_reset_mid();
    issue_start(8'h40, 8'h50, 1'b1);
    tick(); tick(); tick();
    n_checks++;
    if (count_out !== 8'h42) $display("FAIL rstmid_pre: got count=%h required 42", count_out);
    else n_pass++;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++;
    if (count_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_clear: got count=%h busy=%b done=%b required 00/0/0", count_out, busy, done);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || count_out !== 8'h00)
        $display("FAIL rstmid_quiet[%0d]: got done=%b busy=%b count=%h required 0/0/00",
                 i, done, busy, count_out);
      else n_pass++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_equal();
    test_reload();
    test_abort();
    test_abort_start_idle();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
